// File: rtl/bp_fe_ras_ckpt.sv
// rtl/bp_fe_ras_ckpt.sv - return address stack with checkpoint/restore; optional top repair under BP_FE_RAS_CKPT_TOP_EN
module bp_fe_ras_ckpt #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int ptr_width_lp = $clog2(ras_els_p),
    localparam int cnt_width_lp = $clog2(ras_els_p + 1),
`ifdef BP_FE_RAS_CKPT_TOP_EN
    localparam int ckpt_width_lp = vaddr_width_p + cnt_width_lp + ptr_width_lp
`else
    localparam int ckpt_width_lp = cnt_width_lp + ptr_width_lp
`endif
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     call_i,
    input  logic                     return_i,
    input  logic [vaddr_width_p-1:0] addr_i,
    output logic [vaddr_width_p-1:0] tgt_o,
    output logic                     v_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
    output logic                     full_o
);

    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(ras_els_p);

    logic [vaddr_width_p-1:0] mem [ras_els_p];
    logic [ptr_width_lp-1:0]  ptr, ptr_n, waddr;
    logic [cnt_width_lp-1:0]  cnt, cnt_n;
    logic [vaddr_width_p-1:0] wdata;
    logic                     we;

    logic [ptr_width_lp-1:0]  rptr;
    logic [cnt_width_lp-1:0]  rcnt;

    assign rptr = restore_ckpt_i[ptr_width_lp-1:0];
    assign rcnt = restore_ckpt_i[ptr_width_lp +: cnt_width_lp];

    assign tgt_o  = mem[ptr];
    assign v_o    = (cnt != '0);
    assign full_o = (cnt == full_cnt_lp);
`ifdef BP_FE_RAS_CKPT_TOP_EN
    assign ckpt_o = {mem[ptr], cnt, ptr};
`else
    assign ckpt_o = {cnt, ptr};
`endif

    always_comb begin
        ptr_n = ptr;
        cnt_n = cnt;
        we    = 1'b0;
        waddr = ptr;
        wdata = addr_i;
        if (restore_v_i) begin
            // Any call/return in the same cycle belongs to the squashed path.
            ptr_n = rptr;
            cnt_n = (rcnt > full_cnt_lp) ? full_cnt_lp : rcnt;
`ifdef BP_FE_RAS_CKPT_TOP_EN
            we    = 1'b1;
            waddr = rptr;
            wdata = restore_ckpt_i[ckpt_width_lp-1 -: vaddr_width_p];
`endif
        end else if (call_i && return_i) begin
            we    = 1'b1;
            cnt_n = (cnt == '0) ? cnt_width_lp'(1) : cnt;
        end else if (call_i) begin
            // Full stack wraps onto the oldest entry; count saturates.
            ptr_n = ptr + ptr_width_lp'(1);
            waddr = ptr + ptr_width_lp'(1);
            we    = 1'b1;
            cnt_n = full_o ? cnt : cnt + cnt_width_lp'(1);
        end else if (return_i && v_o) begin
            ptr_n = ptr - ptr_width_lp'(1);
            cnt_n = cnt - cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < ras_els_p; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ptr <= ptr_n;
            cnt <= cnt_n;
            if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end

endmodule
